// File: rtl/stacker_pkg.sv
// Shared types and constants for the stacker block-array write path.
package stacker_pkg;

  localparam int ROWS  = 8;
  localparam int WIDTH = 8;
  localparam int ROW_W = $clog2(ROWS);

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic REQ_GAME = 1'b0;
  localparam logic REQ_PAT  = 1'b1;

  localparam row_t LAST_ROW = row_t'(ROWS - 1);

endpackage

// File: rtl/row_write_slot.sv
// One-entry holding slot for a row write; a push in the flush cycle survives
// because that write is ordered after the clear.
module row_write_slot
  import stacker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [ROW_W-1:0] row_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic [ROW_W-1:0] row_o,
  output logic [WIDTH-1:0] data_o
);

  logic  full_q, full_d;
  row_t  row_q;
  data_t data_q;
  logic  push;

  assign ready_o = ~full_q;
  assign push    = valid_i & ~full_q;

  always_comb begin
    full_d = full_q;
    if (push)                 full_d = 1'b1;
    else if (flush_i | pop_i) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      row_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (push) begin
        row_q  <= row_i;
        data_q <= data_i;
      end
    end
  end

  assign full_o = full_q;
  assign row_o  = row_q;
  assign data_o = data_q;

endmodule

// File: rtl/blockarray_write_arbiter.sv
// Shares the block array write port between clear, game and pattern writers;
// all writes are deferred to vertical blanking. Also emits the frame tick.
//   state  | meaning
//   IDLE   | waiting for vblank with work pending
//   CLEAR  | writing zero to row cnt, one row per cycle
//   COMMIT | single-cycle write of the selected slot
module blockarray_write_arbiter
  import stacker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             vblank,
  input  logic             clr_req,
  output logic             clr_done,
  input  logic             game_valid,
  output logic             game_ready,
  input  logic [ROW_W-1:0] game_row,
  input  logic [WIDTH-1:0] game_data,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [ROW_W-1:0] pat_row,
  input  logic [WIDTH-1:0] pat_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [WIDTH-1:0] wr_data,
  output logic             frame_tick,
  output logic             busy
);

  state_e state_q;
  row_t   cnt_q;
  logic   vb_q;
  logic   clear_pending_q, clear_pending_d;
  logic   wr_en_q, clr_done_q, frame_tick_q;
  row_t   wr_row_q;
  data_t  wr_data_q;

  logic   game_full, pat_full;
  row_t   game_slot_row, pat_slot_row;
  data_t  game_slot_data, pat_slot_data;

  logic   go_clear, go_game, go_pat, commit_sel;
  row_t   commit_row;
  data_t  commit_data;

  row_write_slot u_game_slot (
    .clk     (clk),
    .reset   (reset),
    .valid_i (game_valid),
    .ready_o (game_ready),
    .row_i   (game_row),
    .data_i  (game_data),
    .pop_i   (go_game),
    .flush_i (clr_req),
    .full_o  (game_full),
    .row_o   (game_slot_row),
    .data_o  (game_slot_data)
  );

  row_write_slot u_pat_slot (
    .clk     (clk),
    .reset   (reset),
    .valid_i (pat_valid),
    .ready_o (pat_ready),
    .row_i   (pat_row),
    .data_i  (pat_data),
    .pop_i   (go_pat),
    .flush_i (clr_req),
    .full_o  (pat_full),
    .row_o   (pat_slot_row),
    .data_o  (pat_slot_data)
  );

  always_comb begin
    go_clear = 1'b0;
    go_game  = 1'b0;
    go_pat   = 1'b0;
    if (state_q == IDLE && vb_q) begin
      if (clear_pending_q) go_clear = 1'b1;
      else if (game_full)  go_game  = 1'b1;
      else if (pat_full)   go_pat   = 1'b1;
    end
    commit_sel  = go_game ? REQ_GAME : REQ_PAT;
    commit_row  = (commit_sel == REQ_GAME) ? game_slot_row  : pat_slot_row;
    commit_data = (commit_sel == REQ_GAME) ? game_slot_data : pat_slot_data;

    // A clr_req landing on the final clear row is absorbed, not re-queued.
    clear_pending_d = clear_pending_q;
    if (state_q == CLEAR && cnt_q == LAST_ROW) clear_pending_d = 1'b0;
    else if (clr_req)                          clear_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      vb_q            <= 1'b0;
      clear_pending_q <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_row_q        <= '0;
      wr_data_q       <= '0;
      clr_done_q      <= 1'b0;
      frame_tick_q    <= 1'b0;
    end else begin
      vb_q            <= vblank;
      frame_tick_q    <= vblank & ~vb_q;
      clear_pending_q <= clear_pending_d;
      wr_en_q         <= 1'b0;
      clr_done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_clear) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            wr_en_q   <= 1'b1;
            wr_row_q  <= '0;
            wr_data_q <= '0;
          end else if (go_game || go_pat) begin
            state_q   <= COMMIT;
            wr_en_q   <= 1'b1;
            wr_row_q  <= commit_row;
            wr_data_q <= commit_data;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ROW) begin
            clr_done_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            wr_en_q   <= 1'b1;
            wr_row_q  <= cnt_q + 1'b1;
            wr_data_q <= '0;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_data    = wr_data_q;
  assign clr_done   = clr_done_q;
  assign frame_tick = frame_tick_q;
  assign busy       = (state_q != IDLE) | clear_pending_q | game_full | pat_full;

endmodule

// File: tb/tb_blockarray_write_arbiter.sv
// Directed bench for the block-array write arbiter.
module tb_blockarray_write_arbiter;

  logic       clk = 1'b0;
  logic       reset, vblank, clr_req;
  logic       clr_done;
  logic       game_valid, game_ready;
  logic [2:0] game_row;
  logic [7:0] game_data;
  logic       pat_valid, pat_ready;
  logic [2:0] pat_row;
  logic [7:0] pat_data;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       frame_tick, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ft_cnt = 0;
  int done_cnt = 0;
  int wq_row[$];
  int wq_data[$];
  int wq_cyc[$];

  blockarray_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vblank     (vblank),
    .clr_req    (clr_req),
    .clr_done   (clr_done),
    .game_valid (game_valid),
    .game_ready (game_ready),
    .game_row   (game_row),
    .game_data  (game_data),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_row    (pat_row),
    .pat_data   (pat_data),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_row.push_back(int'(wr_row));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(cyc);
    end
    if (frame_tick) ft_cnt++;
    if (clr_done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wq_row.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic game_write(input logic [2:0] r, input logic [7:0] d);
    game_valid = 1'b1; game_row = r; game_data = d;
    tick();
    game_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vblank = 1'b0; clr_req = 1'b0;
    game_valid = 1'b0; game_row = '0; game_data = '0;
    pat_valid = 1'b0; pat_row = '0; pat_data = '0;
    tick(3);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_game_ready", game_ready, 1);
    check_val("rst_pat_ready", pat_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_tick", frame_tick, 0);
    reset = 1'b0;
    tick();
    check_val("idle_wr_row", wr_row, 0);
    check_val("idle_clr_done", clr_done, 0);

    // game write during active video waits for vblank
    clear_log();
    game_write(3'd3, 8'h3C);
    check_val("s1_game_ready_busy", game_ready, 0);
    check_val("s1_busy", busy, 1);
    tick(4);
    check_val("s1_no_write_active", wq_row.size(), 0);
    vblank = 1'b1;
    tick();
    check_val("s1_wr_en_edge1", wr_en, 0);
    check_val("s1_frame_tick", frame_tick, 1);
    tick();
    check_val("s1_wr_en", wr_en, 1);
    check_val("s1_wr_row", wr_row, 3);
    check_val("s1_wr_data", wr_data, 8'h3C);
    check_val("s1_game_ready", game_ready, 1);
    tick();
    check_val("s1_wr_en_off", wr_en, 0);
    check_val("s1_frame_tick_off", frame_tick, 0);
    check_val("s1_busy_off", busy, 0);

    // clear with vblank already high
    tick(2);
    clear_log();
    done_cnt = 0;
    pulse_clr();
    check_val("s2_pending_no_write", wr_en, 0);
    check_val("s2_busy", busy, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("s2_wr_en_%0d", i), wr_en, 1);
      check_val($sformatf("s2_row_%0d", i), wr_row, i);
      check_val($sformatf("s2_data_%0d", i), wr_data, 0);
      tick();
    end
    check_val("s2_wr_en_after", wr_en, 0);
    check_val("s2_clr_done", clr_done, 1);
    tick();
    check_val("s2_clr_done_off", clr_done, 0);
    check_val("s2_busy_off", busy, 0);
    check_val("s2_done_count", done_cnt, 1);

    // priority: game before pattern
    vblank = 1'b0;
    tick(3);
    game_valid = 1'b1; game_row = 3'd5; game_data = 8'hFF;
    pat_valid  = 1'b1; pat_row  = 3'd5; pat_data  = 8'hAA;
    tick();
    game_valid = 1'b0; pat_valid = 1'b0;
    check_val("s3_game_ready", game_ready, 0);
    check_val("s3_pat_ready", pat_ready, 0);
    clear_log();
    vblank = 1'b1;
    tick(6);
    check_val("s3_nwrites", wq_row.size(), 2);
    if (wq_row.size() == 2) begin
      check_val("s3_first_data", wq_data[0], 8'hFF);
      check_val("s3_first_row", wq_row[0], 5);
      check_val("s3_second_data", wq_data[1], 8'hAA);
      check_val("s3_second_row", wq_row[1], 5);
      check_val("s3_spacing", wq_cyc[1] - wq_cyc[0], 2);
    end
    check_val("s3_busy_off", busy, 0);

    // clear flushes older write, keeps newer one
    vblank = 1'b0;
    tick(3);
    game_write(3'd2, 8'h55);
    pulse_clr();
    check_val("s4_flushed_ready", game_ready, 1);
    check_val("s4_busy_pending", busy, 1);
    game_write(3'd7, 8'h18);
    clear_log();
    done_cnt = 0;
    vblank = 1'b1;
    tick(14);
    check_val("s4_nwrites", wq_row.size(), 9);
    if (wq_row.size() == 9) begin
      for (int i = 0; i < 8; i++) begin
        check_val($sformatf("s4_clr_row_%0d", i), wq_row[i], i);
        check_val($sformatf("s4_clr_data_%0d", i), wq_data[i], 0);
      end
      check_val("s4_last_row", wq_row[8], 7);
      check_val("s4_last_data", wq_data[8], 8'h18);
    end
    check_val("s4_done_count", done_cnt, 1);
    check_val("s4_busy_off", busy, 0);

    // vblank drops mid-clear
    vblank = 1'b0;
    tick(3);
    pulse_clr();
    clear_log();
    ft_cnt = 0;
    vblank = 1'b1;
    tick(6);
    check_val("s5_row4_en", wr_en, 1);
    check_val("s5_row4", wr_row, 4);
    vblank = 1'b0;
    tick(6);
    check_val("s5_nwrites", wq_row.size(), 8);
    if (wq_row.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_val($sformatf("s5_row_%0d", i), wq_row[i], i);
        check_val($sformatf("s5_cyc_%0d", i), wq_cyc[i] - wq_cyc[0], i);
      end
    end
    check_val("s5_frame_ticks", ft_cnt, 1);
    check_val("s5_busy_off", busy, 0);

    // reset mid-clear
    vblank = 1'b1;
    tick(2);
    pulse_clr();
    tick();
    check_val("s6_row0", wr_row, 0);
    pat_valid = 1'b1; pat_row = 3'd1; pat_data = 8'h81;
    tick();
    pat_valid = 1'b0;
    check_val("s6_pat_ready_full", pat_ready, 0);
    tick();
    check_val("s6_row2_en", wr_en, 1);
    check_val("s6_row2", wr_row, 2);
    reset = 1'b1;
    tick();
    check_val("s6_rst_wr_en", wr_en, 0);
    check_val("s6_rst_busy", busy, 0);
    check_val("s6_rst_game_ready", game_ready, 1);
    check_val("s6_rst_pat_ready", pat_ready, 1);
    reset = 1'b0;
    clear_log();
    tick(4);
    check_val("s6_no_writes_after", wq_row.size(), 0);
    check_val("s6_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
